// File: rtl/hog_window_packetizer.sv
// Multi-level HOG window packetizer.
// Accepts whole detection windows from LEVELS pyramid levels, arbitrates at
// window granularity (round-robin or fixed priority) and streams each granted
// window as an optional header beat followed by BEATS data beats, LSB-first.
// The header layout needs BUS_WIDTH >= META_WIDTH + 16.
module hog_window_packetizer #(
  parameter int WINDOW_WIDTH = 1152,
  parameter int BUS_WIDTH    = 128,
  parameter int LEVELS       = 7,
  parameter int META_WIDTH   = 3,
  parameter int ARB_MODE     = 0,
  parameter int HEADER       = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [LEVELS-1:0]              in_valid,
  input  logic [LEVELS*WINDOW_WIDTH-1:0] in_window,
  output logic [LEVELS-1:0]              in_ready,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [BUS_WIDTH-1:0]           out_stream,
  output logic                           out_last,
  output logic [META_WIDTH-1:0]          out_level
);

  localparam int BEATS  = (WINDOW_WIDTH + BUS_WIDTH - 1) / BUS_WIDTH;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PAD_W  = BEATS * BUS_WIDTH;

  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

  state_t                  state, state_nxt;
  logic [WINDOW_WIDTH-1:0] window_q;
  logic [BEAT_W-1:0]       beat_q;
  logic [META_WIDTH-1:0]   level_q;
  logic [META_WIDTH-1:0]   ptr_q;
  logic [META_WIDTH-1:0]   grant;
  logic [15:0]             win_cnt_q;
  logic                    grant_any;
  logic                    in_hs;
  logic                    out_hs;
  logic                    last_beat;
  logic [PAD_W-1:0]        padded;
  logic [BUS_WIDTH-1:0]    hdr_beat;

  // Arbiter: first valid level, searching from ptr_q (round-robin) or from 0.
  always_comb begin
    int idx;
    // NOTE: every signal driven here gets a default before any branch, so no latch is inferred.
    idx       = 0;
    grant     = '0;
    grant_any = 1'b0;
    for (int i = 0; i < LEVELS; i++) begin
      idx = (ARB_MODE == 1) ? i : (int'(ptr_q) + i) % LEVELS;
      if (!grant_any && in_valid[idx]) begin
        grant_any = 1'b1;
        grant     = META_WIDTH'(idx);
      end
    end
  end

  // Handshake decode; in_ready depends only on in_valid, state and pointer.
  always_comb begin
    in_ready  = '0;
    if (rst_n && state == IDLE && grant_any)
      in_ready = LEVELS'(1) << grant;
    in_hs     = |in_ready;
    out_valid = (state != IDLE);
    out_hs    = out_valid && out_ready;
    last_beat = (state == DATA) && (beat_q == BEAT_W'(BEATS - 1));
    out_last  = last_beat;
    out_level = level_q;
  end

  // Next-state logic for the packet FSM.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_any) state_nxt = (HEADER != 0) ? HDR : DATA;
      HDR:     if (out_ready) state_nxt = DATA;
      DATA:    if (out_ready && last_beat) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Beat formatting: header word or a zero-padded slice of the held window.
  always_comb begin
    padded                           = '0;
    padded[WINDOW_WIDTH-1:0]         = window_q;
    hdr_beat                         = '0;
    hdr_beat[META_WIDTH-1:0]         = level_q;
    hdr_beat[META_WIDTH +: 16]       = win_cnt_q;
    out_stream                       = '0;
    case (state)
      HDR:     out_stream = hdr_beat;
      DATA:    out_stream = padded[int'(beat_q)*BUS_WIDTH +: BUS_WIDTH];
      default: out_stream = '0;
    endcase
  end

  // Control state: FSM, arbitration pointer, packet level, beat index, window count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr_q     <= '0;
      level_q   <= '0;
      beat_q    <= '0;
      win_cnt_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state <= state_nxt;
      if (in_hs) begin
        level_q <= grant;
        ptr_q   <= (int'(grant) == LEVELS - 1) ? '0 : grant + 1'b1;
        beat_q  <= '0;
      end
      if (out_hs && state == DATA) begin
        beat_q <= last_beat ? '0 : beat_q + 1'b1;
        if (last_beat) win_cnt_q <= win_cnt_q + 16'd1;
      end
    end
  end

  // Window holding register, loaded on the input handshake.
  // NOTE: the data register has no reset; it is only observed after a load, and the FSM gates it.
  always_ff @(posedge clk) begin
    if (in_hs) window_q <= in_window[int'(grant)*WINDOW_WIDTH +: WINDOW_WIDTH];
  end

endmodule

// File: doc/hog_window_packetizer.md
# hog_window_packetizer

Parametrised multi-level successor to the per-level window serializer plus bus switch pair. It accepts complete HOG detection windows from `LEVELS` pyramid levels and arbitrates between them at window granularity. Each granted window is emitted on a single `BUS_WIDTH` stream as an optional header beat followed by `BEATS` data beats. It sits in the fast clock domain between the per-level async FIFOs and the HPS bridge adapter.

## Interface
- `WINDOW_WIDTH`, 1152: bits per detection window.
- `BUS_WIDTH`, 128: output stream width.
- `LEVELS`, 7: number of input levels; must be >= 1 and <= 2^`META_WIDTH`.
- `META_WIDTH`, 3: width of the level id.
- `ARB_MODE`, 0: 0 = round-robin; 1 = fixed priority, lowest index wins.
- `HEADER`, 1: 1 = prepend a header beat; 0 = data beats only.
- Derived: `BEATS` = ceil(`WINDOW_WIDTH`/`BUS_WIDTH`).

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  `LEVELS`  per-level window valid.
- `in_window`  in  `LEVELS*WINDOW_WIDTH`  level j occupies `[j*WINDOW_WIDTH +: WINDOW_WIDTH]`.
- `in_ready`  out  `LEVELS`  per-level accept; at most one bit high.
- `out_valid`  out  1  stream beat valid.
- `out_ready`  in  1  downstream accept.
- `out_stream`  out  `BUS_WIDTH`  beat data.
- `out_last`  out  1  high on the final beat of a packet.
- `out_level`  out  `META_WIDTH`  level id of the current packet; constant for the whole packet.

## Operation
- FSM states: IDLE, HDR, DATA.
- **IDLE**
  - If any `in_valid` is high, the arbiter selects grant g and drives `in_ready[g]`=1 combinationally.
  - On the handshake, the window is latched into the holding register, g is latched into `out_level`, and the FSM moves to HDR (`HEADER`=1) or DATA (`HEADER`=0).
  - `in_ready` is 0 in HDR and DATA.
- **Round-robin arbitration:** search starts at pointer p, wrapping modulo `LEVELS`. After each grant, p = (g+1) mod `LEVELS`. p resets to 0.
- **Fixed-priority arbitration:** the lowest valid index wins. p is unused.
- **HDR**
  - `out_stream` = {zero pad, `win_cnt`[15:0], g[`META_WIDTH`-1:0]}, with g in the LSBs.
  - On handshake, go to DATA with beat index k=0.
- **DATA**
  - Beat k = `window[k*BUS_WIDTH +: BUS_WIDTH]`, LSB-first.
  - Bits beyond `WINDOW_WIDTH` in the last beat are zero.
  - k increments only on handshake.
  - On the handshake of k=`BEATS`-1, `out_last` is 1, `win_cnt` increments (16-bit, wraps 65535 to 0), and the FSM returns to IDLE.
- **Handshake rules**
  - Once `out_valid`=1, `out_stream`, `out_last` and `out_level` hold stable until `out_ready`=1.
  - `out_valid` never drops without a handshake.
- **Arbitration timing:** requests that arrive mid-packet wait. The grant is evaluated only in IDLE, and a held `in_valid` is not lost.
- **Single-level configuration:** `LEVELS`=1 degenerates to a plain serializer; p stays 0.
- **Reset**
  - Asserting reset mid-packet aborts the packet and drops the partial window.
  - All outputs go to reset values immediately (asynchronous).

## Timing
- **Reset values:** `out_valid`=0, `out_stream`=0, `out_last`=0, `out_level`=0, `in_ready`=0 (forced while `rst_n`=0), FSM=IDLE, p=0, `win_cnt`=0.
- **Latency:** from the `in_valid`/`in_ready` handshake at edge N, the first beat is valid after edge N (cycle N+1).
- **Packet length:** `BEATS`+`HEADER` beats, one per cycle when `out_ready`=1 continuously.
- **Inter-packet gap:** one IDLE bubble cycle between packets (`out_valid`=0). Maximum throughput is therefore one window per `BEATS`+`HEADER`+1 cycles; with defaults that is 11 cycles.
- **`in_ready` dependence:** `in_ready` is a combinational function of `in_valid`, state and p. No combinational path exists from `out_ready` to `in_ready`.
- **Simultaneous events:** if new `in_valid` bits rise on the same edge as the last-beat handshake, they are considered in the following IDLE cycle.

## Test plan
- **Single window, level 3, defaults, `out_ready`=1:**
  - Expect 10 beats.
  - Header LSBs = 3'd3 and `win_cnt`=0.
  - Data beats 0..8 equal window slices; `out_last` only on beat 9; `out_level`=3 throughout.
- **Backpressure:** toggle `out_ready` randomly (50%) during a packet.
  - Every beat appears exactly once, in order.
  - Data holds stable while `out_ready`=0; no beat is dropped or duplicated.
- **Round-robin, all 7 `in_valid` held high, `ARB_MODE`=0:**
  - Grant order 0,1,2,3,4,5,6,0.
  - `win_cnt` in headers is 0..7; `in_ready` is one-hot at each grant.
- **Fixed priority, `ARB_MODE`=1, levels 2 and 5 held valid:**
  - Level 2 is granted every time; level 5 is never granted until `in_valid[2]` drops, then level 5 is granted next.
- **Non-multiple width, `WINDOW_WIDTH`=200, `BUS_WIDTH`=64, `HEADER`=0:**
  - Expect 4 beats.
  - Beat 3 = {56'b0, window[199:192]}; `out_last` on beat 3.
- **Reset mid-packet:** assert `rst_n`=0 during beat 4, then release.
  - `out_valid` goes to 0 immediately.
  - After release, the next grant starts at level 0 (p reset) with `win_cnt`=0.
